// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised integer register file.
package rf_pkg;

    localparam int unsigned RF_XLEN = 32;
    localparam int unsigned RF_NREG = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_e;

    // One byte lane of a byte-masked write: take the new byte where enabled.
    function automatic logic [7:0] rf_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: array mux, hard-wired zero and same-cycle write bypass.
module rf_read_port
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN     = RF_XLEN,
    parameter  int unsigned NREG     = RF_NREG,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = $clog2(NREG),
    localparam int unsigned NB       = XLEN / 8
) (
    input  logic                 idle_i,
    input  logic [NREG*XLEN-1:0] regs_i,
    input  logic [AW-1:0]        ra_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        wa_i,
    input  logic [NB-1:0]        wbe_i,
    input  logic [XLEN-1:0]      wd_i,
    output logic [XLEN-1:0]      rd_o
);

    logic [XLEN-1:0] stored;

    always_comb begin
        stored = regs_i[32'(ra_i) * XLEN +: XLEN];
        rd_o   = stored;
        if (!idle_i || (ZERO_REG != 0 && ra_i == '0)) begin
            rd_o = '0;
        end else if (BYPASS != 0 && we_i && wa_i == ra_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                rd_o[8*i +: 8] = rf_merge(stored[8*i +: 8], wd_i[8*i +: 8], wbe_i[i]);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with byte-enabled writes, optional bypass
// and a one-entry-per-cycle clear sweep after reset or on request.
module regfile_mp
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN     = RF_XLEN,
    parameter  int unsigned NREG     = RF_NREG,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = $clog2(NREG),
    localparam int unsigned NB       = XLEN / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    output logic                busy,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [NB-1:0]       wbe,
    input  logic [XLEN-1:0]     wd
);

    rf_state_e             state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [XLEN-1:0]       mem_q [NREG];
    logic [NREG*XLEN-1:0]  regs_flat;
    logic [XLEN-1:0]       wr_merged;
    logic                  wr_en;
    logic                  idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREG - 1)) state_d = RF_IDLE;
            end
            RF_IDLE: begin
                if (clear) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    always_comb begin
        busy = (state_q == RF_CLEAR);
        idle = (state_q == RF_IDLE);
    end

    always_comb begin
        wr_en = idle && we && !(ZERO_REG != 0 && wa == '0);
        for (int unsigned i = 0; i < NB; i++) begin
            wr_merged[8*i +: 8] = rf_merge(mem_q[wa][8*i +: 8], wd[8*i +: 8], wbe[i]);
        end
    end

    // Array has no reset; the sweep is what makes its contents known.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[wa] <= wr_merged;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_flat
        assign regs_flat[r*XLEN +: XLEN] = mem_q[r];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .idle_i (idle),
            .regs_i (regs_flat),
            .ra_i   (ra[k*AW +: AW]),
            .we_i   (we),
            .wa_i   (wa),
            .wbe_i  (wbe),
            .wd_i   (wd),
            .rd_o   (rd[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (default, no bypass, no zero reg) share stimulus.
module tb_regfile_mp;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  ra = '0;
    logic [4:0]  wa = '0;
    logic [3:0]  wbe = '0;
    logic [31:0] wd = '0;
    logic [63:0] rd_a, rd_b, rd_c;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy_a), .ra(ra), .rd(rd_a),
        .we(we), .wa(wa), .wbe(wbe), .wd(wd));
    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy_b), .ra(ra), .rd(rd_b),
        .we(we), .wa(wa), .wbe(wbe), .wd(wd));
    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy_c), .ra(ra), .rd(rd_c),
        .we(we), .wa(wa), .wbe(wbe), .wd(wd));

    typedef struct {
        string       tag;
        int unsigned d;
        int unsigned p;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] got;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_z  [NREG];
    logic [31:0] model_nz [NREG];
    bit          idle_m = 1'b0;

    function automatic logic [31:0] rd_of(input int unsigned d, input int unsigned p);
        case (d)
            0:       return rd_a[p*32 +: 32];
            1:       return rd_b[p*32 +: 32];
            default: return rd_c[p*32 +: 32];
        endcase
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old_v);
        logic [31:0] v;
        v = old_v;
        for (int i = 0; i < 4; i++) if (wbe[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    // Expected read for instance d: 0 = zero+bypass, 1 = zero only, 2 = bypass only.
    function automatic logic [31:0] predict(input int unsigned d, input logic [AW-1:0] a);
        logic [31:0] v;
        bit zr, byp;
        zr  = (d != 2);
        byp = (d != 1);
        if (!idle_m) return 32'h0;
        if (zr && a == 0) return 32'h0;
        v = (d == 2) ? model_nz[a] : model_z[a];
        if (byp && we && wa == a) v = merged(v);
        return v;
    endfunction

    task automatic drive(input string tag, input bit w, input logic [4:0] a_w,
                         input logic [3:0] be, input logic [31:0] dat,
                         input logic [4:0] r0, input logic [4:0] r1);
        we  = w;
        wa  = a_w;
        wbe = be;
        wd  = dat;
        ra  = {r1, r0};
        for (int unsigned d = 0; d < 3; d++) begin
            sb.push_back('{tag, d, 0, predict(d, r0)});
            sb.push_back('{tag, d, 1, predict(d, r1)});
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (idle_m && we) begin
            if (wa != 0) model_z[wa] = merged(model_z[wa]);
            model_nz[wa] = merged(model_nz[wa]);
        end
        #1;
        we = 1'b0;
    endtask

    task automatic zero_models();
        for (int i = 0; i < NREG; i++) begin
            model_z[i]  = 32'h0;
            model_nz[i] = 32'h0;
        end
    endtask

    task automatic test_read_all(input string tag);
        for (int r = 0; r < 16; r++) begin
            drive(tag, 1'b0, 5'd0, 4'h0, 32'h0, 5'(r), 5'(r + 16));
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = rd_of(e.d, e.p);
                n_tests++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
                end
            end
            commit();
        end
    endtask

    task automatic count_busy(input string tag);
        int cyc;
        cyc = 0;
        while (busy_a === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== 32) begin
            n_fail++;
            $display("FAIL %s busy_edges: got %0d expected 32", tag, cyc);
        end
        n_tests++;
        if (busy_b !== 1'b0 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_others: got %b%b expected 00", tag, busy_b, busy_c);
        end
        idle_m = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        drive("reset_rd", 1'b1, 5'd3, 4'hF, 32'hFFFF_FFFF, 5'd3, 5'd0);
        @(negedge clk);
        n_tests++;
        if ({busy_a, busy_b, busy_c} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_busy: got %b%b%b expected 111", busy_a, busy_b, busy_c);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = rd_of(e.d, e.p);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
            end
        end
        @(posedge clk);
        #1;
        we  = 1'b0;
        rst = 1'b0;
        zero_models();
        count_busy("reset");
        test_read_all("reset_all_zero");
    endtask

    task automatic test_write();
        drive("wr_bypass", 1'b1, 5'd5, 4'hF, 32'hDEAD_BEEF, 5'd5, 5'd5);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = rd_of(e.d, e.p);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
            end
        end
        commit();
        drive("wr_after", 1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd4);
        drive("byte_bypass", 1'b1, 5'd5, 4'b0101, 32'h1122_3344, 5'd5, 5'd5);
        // the second drive overrode inputs; drop the stale entries and re-push for the live cycle
        sb.delete();
        drive("byte_bypass", 1'b1, 5'd5, 4'b0101, 32'h1122_3344, 5'd5, 5'd5);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = rd_of(e.d, e.p);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
            end
        end
        commit();
        drive("byte_after", 1'b1, 5'd5, 4'h0, 32'hFFFF_FFFF, 5'd5, 5'd6);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = rd_of(e.d, e.p);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
            end
        end
        commit();
        n_tests++;
        if (model_z[5] !== 32'hDE22_BE44) begin
            n_fail++;
            $display("FAIL byte_model: got %h expected de22be44", model_z[5]);
        end
    endtask

    task automatic test_zero_reg();
        for (int k = 0; k < 2; k++) begin
            drive(k == 0 ? "x0_same" : "x0_after", k == 0, 5'd0, 4'hF, 32'hFFFF_FFFF, 5'd0, 5'd0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = rd_of(e.d, e.p);
                n_tests++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
                end
            end
            commit();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dat;
        for (int r = 1; r <= 8; r++) begin
            dat = $urandom;
            drive("b2b", 1'b1, 5'(r), 4'($urandom_range(0, 15)), dat, 5'(r), 5'(r - 1));
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = rd_of(e.d, e.p);
                n_tests++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
                end
            end
            commit();
        end
    endtask

    task automatic test_clear();
        int cyc;
        clear = 1'b1;
        drive("clr_wr", 1'b1, 5'd7, 4'hF, 32'hCAFE_F00D, 5'd7, 5'd5);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = rd_of(e.d, e.p);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
            end
        end
        commit();
        clear  = 1'b0;
        idle_m = 1'b0;
        zero_models();
        cyc = 0;
        while (busy_a === 1'b1 && cyc < 100) begin
            clear = cyc[0];
            drive("sweep_rd", 1'b1, 5'(cyc + 9), 4'hF, $urandom, 5'(cyc + 9), 5'd7);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = rd_of(e.d, e.p);
                n_tests++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.d, e.p, got, e.val);
                end
            end
            commit();
            cyc++;
        end
        clear = 1'b0;
        n_tests++;
        if (cyc !== 32) begin
            n_fail++;
            $display("FAIL clear busy_edges: got %0d expected 32", cyc);
        end
        idle_m = 1'b1;
        test_read_all("clear_all_zero");
    endtask

    task automatic test_reset_mid_sweep();
        drive("pre", 1'b1, 5'd4, 4'hF, 32'h55AA_55AA, 5'd4, 5'd4);
        sb.delete();
        commit();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        idle_m = 1'b0;
        zero_models();
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #2;
        n_tests++;
        if ({busy_a, busy_b, busy_c} !== 3'b111) begin
            n_fail++;
            $display("FAIL midrst_busy: got %b%b%b expected 111", busy_a, busy_b, busy_c);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy("midrst");
        test_read_all("midrst_all_zero");
    endtask

    initial begin
        zero_models();
        test_reset();
        test_write();
        test_zero_reg();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised successor to the core's integer register file: configurable data width, register count and number of read ports, byte-enabled writes, optional write-to-read bypass, and a hardware clear sequencer that zeroes the array one entry per cycle after reset or on request. It sits in the decode stage of the rv32i datapath. A `busy` output stalls the pipeline until the array holds known values.

## Interface
- `XLEN`, 32: register width in bits; a multiple of 8.
- `NREG`, 32: number of registers; a power of 2, ≥ 2. `AW = log2(NREG)`.
- `NRD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: when 1, register 0 is hard-wired to zero.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: request a full clear sweep. Sampled only in IDLE.
- `busy` output 1: high while the sweep runs. Reads and writes are invalid while it is high.
- `ra` input `NRD*AW`: read addresses. Port k uses bits `[k*AW +: AW]`.
- `rd` output `NRD*XLEN`: read data. Port k uses bits `[k*XLEN +: XLEN]`.
- `we` input 1: write enable.
- `wa` input `AW`: write address.
- `wbe` input `XLEN/8`: byte enables. Bit i covers bits `[8i +: 8]`.
- `wd` input `XLEN`: write data.

## Operation
- The FSM has two states, CLEAR and IDLE, plus a sweep counter `cnt` of width `AW`.
- Under `rst`: state = CLEAR, `cnt` = 0, `busy` = 1. The array contents are not reset directly.
- CLEAR: each edge writes 0 to `reg[cnt]` and increments `cnt`. The edge on which `cnt == NREG-1` moves the FSM to IDLE.
  - `we` is ignored; the write is dropped with no retry.
  - `clear` is ignored; the sweep does not restart.
  - All `rd` ports return 0.
- IDLE: `busy` = 0.
  - If `we`, and not (`ZERO_REG` and `wa == 0`): every byte with `wbe[i]` set is written from `wd`. Other bytes are unchanged.
  - If `clear` is high: state = CLEAR and `cnt` = 0 on the next edge. A write in the same cycle as `clear` is still performed, then overwritten by the sweep.
- Reads (IDLE only), in priority order:
  1. If `ZERO_REG` and `ra_k == 0`: `rd_k` = 0.
  2. Else, if `BYPASS`, `we`, and `wa == ra_k`: `rd_k` is the merged value, new bytes where `wbe` is set and stored bytes elsewhere.
  3. Else: `rd_k = reg[ra_k]`.
- All read ports are independent. Any number of them may address the same register.
- `wbe` = 0 with `we` = 1 is a legal no-op. It bypasses the unchanged stored value.

## Timing
- Reads are combinational from `ra`, `we`, `wa`, `wbe`, `wd` and the array; zero latency.
- A write is visible to a non-bypassed read on the cycle after the edge.
- Reset to IDLE: `busy` is high for exactly `NREG` rising edges after `rst` deasserts and falls after the `NREG`-th edge.
- `clear` in IDLE: `busy` rises after the next edge and stays high for `NREG` edges.
- Reset asserted mid-sweep: the sweep restarts from `cnt` = 0.
- Output reset values: `busy` = 1; all `rd` = 0.

## Structure
- Shared package `rf_pkg`:
  - state enum `RF_CLEAR`, `RF_IDLE`;
  - `rf_merge` function (byte-mask merge);
  - default `XLEN` / `NREG` constants shared with the decode stage.
- One natural sub-module, `rf_read_port`: one read mux plus the zero and bypass logic. It is instantiated `NRD` times in a generate loop.
- The FSM, counter and storage array stay in the top module.

## Test plan
- Reset, then release: `busy` = 1 for 32 cycles. Then read all 32 registers -> all return 0x0000_0000.
- IDLE write: `wa`=5, `wd`=0xDEAD_BEEF, `wbe`=0xF. Next cycle `ra0`=5 -> 0xDEADBEEF. Same-cycle read with `BYPASS`=1 -> 0xDEADBEEF; with `BYPASS`=0 -> 0x0000_0000.
- Byte write to x5 (holding 0xDEADBEEF): `wd`=0x1122_3344, `wbe`=0b0101 -> x5 reads 0xDE22BE44, both bypassed and after the edge.
- Write `wa`=0, `wd`=0xFFFF_FFFF -> `ra`=0 reads 0 on every port, same cycle and after. With `ZERO_REG`=0 -> reads 0xFFFFFFFF next cycle.
- `clear` pulse with a write to x7 in the same cycle -> `busy` = 1 for 32 cycles; writes issued during the sweep are dropped; afterwards x7 and all other registers read 0.
- `rst` asserted at sweep cycle 10 -> `busy` stays high. After release, `busy` is high for a full 32 cycles before IDLE.
